mul_share_arb: RTL and testbench



---
 rtl/mul_arb_pkg.sv | 30 +++
 rtl/mul_share_arb_pick.sv | 40 ++++
 rtl/mul_share_arb.sv | 98 +++++++++
 tb/tb_mul_share_arb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing round-robin arbiter.
// Tags are sized for the largest supported requester count (16).
package mul_arb_pkg;

   localparam int STAT_W  = 16;
   localparam int TAG_IDW = 4;
   localparam int TAG_N   = 1 << TAG_IDW;

   typedef struct packed {
      logic               valid;
      logic [TAG_IDW-1:0] id;
   } mul_tag_t;

   // Unused upper request bits are zero, so a mod-16 search matches a mod-NREQ search.
   function automatic mul_tag_t rr_first(input logic [TAG_N-1:0] valid,
                                         input logic [TAG_IDW-1:0] ptr);
      mul_tag_t           r;
      logic [TAG_IDW-1:0] idx;
      r = '0;
      for (int unsigned k = 0; k < TAG_N; k++) begin
         idx = ptr + TAG_IDW'(k);
         if (!r.valid && valid[idx]) begin
            r.valid = 1'b1;
            r.id    = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_share_arb_pick.sv
// Round-robin requester selection and the rr_ptr register.
import mul_arb_pkg::*;

module mul_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            hold,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   output mul_tag_t        grant
);

   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0] rr_ptr;
   mul_tag_t       pick;

   always_comb begin
      pick      = rr_first(TAG_N'(req_valid), TAG_IDW'(rr_ptr));
      grant     = '0;
      req_ready = '0;
      if (!reset && !hold && pick.valid) begin
         grant = pick;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_ready[i] = grant.valid && (grant.id == TAG_IDW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (grant.valid) begin
         rr_ptr <= (grant.id == TAG_IDW'(NREQ-1)) ? '0 : IDW'(grant.id + 1'b1);
      end
   end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined multiplier among NREQ requesters, routing products back by tag.
// Optional per-requester grant counters: define MUL_ARB_STATS_EN.
import mul_arb_pkg::*;

module mul_share_arb #(
   parameter int BITLEN  = 17,
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hold,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*BITLEN-1:0] req_a,
   input  logic [NREQ*BITLEN-1:0] req_b,
   output logic [BITLEN-1:0]      mul_a,
   output logic [BITLEN-1:0]      mul_b,
   input  logic [2*BITLEN-1:0]    mul_c,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [2*BITLEN-1:0]    rsp_c,
   output logic                   busy
`ifdef MUL_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

   mul_tag_t grant;
   mul_tag_t tag_q [MUL_LAT];

   mul_rr_pick #(.NREQ(NREQ)) u_pick (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .grant     (grant)
   );

   // Idle multiplier inputs are driven to zero to keep them from toggling.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            mul_a = req_a[i*BITLEN +: BITLEN];
            mul_b = req_b[i*BITLEN +: BITLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < MUL_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= grant;
         for (int unsigned k = 1; k < MUL_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
         busy = busy | tag_q[k].valid;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         rsp_valid[i] = tag_q[MUL_LAT-1].valid && (tag_q[MUL_LAT-1].id == TAG_IDW'(i));
      end
   end

   assign rsp_c = mul_c;

`ifdef MUL_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_q [NREQ];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (reset) begin
            cnt_q[i] <= '0;
         end else if (req_ready[i] && (cnt_q[i] != '1)) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Table-driven bench for mul_share_arb with a two-register multiplier model.
module tb_mul_share_arb;

   localparam int BITLEN = 17;
   localparam int NREQ   = 4;

   logic                   clk = 1'b0;
   logic                   reset, hold;
   logic [NREQ-1:0]        req_valid, req_ready, rsp_valid;
   logic [NREQ*BITLEN-1:0] req_a, req_b;
   logic [BITLEN-1:0]      mul_a, mul_b, a_r, b_r;
   logic [2*BITLEN-1:0]    mul_c, rsp_c;
   logic                   busy;
`ifdef MUL_ARB_STATS_EN
   logic [NREQ*16-1:0]     grant_cnt;
`endif

   always #5 clk = ~clk;

   // Multiplier model: input register then output register.
   always_ff @(posedge clk) begin
      a_r   <= mul_a;
      b_r   <= mul_b;
      mul_c <= a_r * b_r;
   end

   mul_share_arb #(.BITLEN(BITLEN), .NREQ(NREQ), .MUL_LAT(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_c     (mul_c),
      .rsp_valid (rsp_valid),
      .rsp_c     (rsp_c),
      .busy      (busy)
`ifdef MUL_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   typedef struct {
      logic                   rst;
      logic                   hld;
      logic [3:0]             v;
      logic [NREQ*BITLEN-1:0] a;
      logic [NREQ*BITLEN-1:0] b;
      logic [3:0]             rdy;
      logic [BITLEN-1:0]      ma;
      logic [3:0]             rsp;
      logic [2*BITLEN-1:0]    c;
      logic                   bsy;
   } row_t;

   row_t rows[$];
   int   passed = 0;
   int   total  = 0;

   function automatic logic [NREQ*BITLEN-1:0] pk(input int a0, input int a1,
                                                  input int a2, input int a3);
      return {BITLEN'(a3), BITLEN'(a2), BITLEN'(a1), BITLEN'(a0)};
   endfunction

   task automatic add(input logic rst, input logic hld, input logic [3:0] v,
                      input logic [NREQ*BITLEN-1:0] a, input logic [NREQ*BITLEN-1:0] b,
                      input logic [3:0] rdy, input logic [BITLEN-1:0] ma,
                      input logic [3:0] rsp, input logic [2*BITLEN-1:0] c, input logic bsy);
      row_t r;
      r.rst = rst; r.hld = hld; r.v = v; r.a = a; r.b = b;
      r.rdy = rdy; r.ma = ma; r.rsp = rsp; r.c = c; r.bsy = bsy;
      rows.push_back(r);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial begin
      logic [NREQ*BITLEN-1:0] z, a4, b10, fs, op3, op5, op6;
      z   = '0;
      a4  = pk(1, 2, 3, 4);
      b10 = pk(10, 10, 10, 10);
      fs  = pk(0, 'h1FFFF, 0, 7);
      op3 = pk(0, 0, 3, 0);
      op5 = pk(0, 0, 5, 0);
      op6 = pk(5, 0, 0, 0);

      // single request from requester 2
      add(0,0,4'b0100, op3, op5, 4'b0100, 17'd3, 4'b0000, 0, 0);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0100, 34'd15, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      add(1,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      // all requesters continuously valid
      add(0,0,4'b1111, a4, b10,  4'b0001, 17'd1, 4'b0000, 0, 0);
      add(0,0,4'b1111, a4, b10,  4'b0010, 17'd2, 4'b0000, 0, 1);
      add(0,0,4'b1111, a4, b10,  4'b0100, 17'd3, 4'b0001, 34'd10, 1);
      add(0,0,4'b1111, a4, b10,  4'b1000, 17'd4, 4'b0010, 34'd20, 1);
      add(0,0,4'b1111, a4, b10,  4'b0001, 17'd1, 4'b0100, 34'd30, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b1000, 34'd40, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0001, 34'd10, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      // full-scale operands, lone requester granted with rr_ptr past it
      add(0,0,4'b0010, fs, fs,   4'b0010, 17'h1FFFF, 4'b0000, 0, 0);
      add(0,0,4'b0010, fs, fs,   4'b0010, 17'h1FFFF, 4'b0000, 0, 1);
      add(0,0,4'b1000, fs, pk(0,0,0,9), 4'b1000, 17'd7, 4'b0010, 34'h3FFFC0001, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0010, 34'h3FFFC0001, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b1000, 34'd63, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      // hold in cycles 1-2
      add(0,0,4'b1111, a4, b10,  4'b0001, 17'd1, 4'b0000, 0, 0);
      add(0,1,4'b1111, a4, b10,  4'b0000, 17'd0, 4'b0000, 0, 1);
      add(0,1,4'b1111, a4, b10,  4'b0000, 17'd0, 4'b0001, 34'd10, 1);
      add(0,0,4'b1111, a4, b10,  4'b0010, 17'd2, 4'b0000, 0, 0);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0010, 34'd20, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      // reset pulse right after an issue (rr_ptr=2, so search wraps to 0)
      add(0,0,4'b0001, op6, op6, 4'b0001, 17'd5, 4'b0000, 0, 0);
      add(1,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);
      add(0,0,4'b1111, a4, b10,  4'b0001, 17'd1, 4'b0000, 0, 0);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0001, 34'd10, 1);
      add(0,0,4'b0000, z, z,     4'b0000, 17'd0, 4'b0000, 0, 0);

      // reset state, requests presented while reset is held
      reset = 1'b1; hold = 1'b0; req_valid = 4'b1111; req_a = a4; req_b = b10;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp",   64'(rsp_valid), 64'(0));
      chk("rst_busy",  64'(busy),      64'(0));
      chk("rst_mul_a", 64'(mul_a),     64'(0));
      @(posedge clk); #1;

      foreach (rows[n]) begin
         reset = rows[n].rst; hold = rows[n].hld; req_valid = rows[n].v;
         req_a = rows[n].a;   req_b = rows[n].b;
         @(negedge clk);
         chk($sformatf("r%0d_ready", n), 64'(req_ready), 64'(rows[n].rdy));
         chk($sformatf("r%0d_mul_a", n), 64'(mul_a),     64'(rows[n].ma));
         chk($sformatf("r%0d_rsp",   n), 64'(rsp_valid), 64'(rows[n].rsp));
         chk($sformatf("r%0d_busy",  n), 64'(busy),      64'(rows[n].bsy));
         if (rows[n].rsp != 4'b0000)
            chk($sformatf("r%0d_rsp_c", n), 64'(rsp_c), 64'(rows[n].c));
         @(posedge clk); #1;
      end

`ifdef MUL_ARB_STATS_EN
      reset = 1'b1; hold = 1'b0; req_valid = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("cnt_reset", 64'(grant_cnt), 64'(0));
      req_valid = 4'b0010;
      for (int k = 0; k < 70000; k++) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("cnt1_sat",  64'(grant_cnt[31:16]), 64'h0000_FFFF);
      chk("cnt_other", 64'({grant_cnt[63:32], grant_cnt[15:0]}), 64'(0));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
